// File: rtl/id_ex_stage_if.sv
// Signal bundle between decode/hazard logic and the ID/EX pipeline register.
// The stage itself uses the slave view; the core (or a bench) drives the master view.
interface id_ex_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              valid_d;
    logic [XLEN-1:0]   rd1_d;
    logic [XLEN-1:0]   rd2_d;
    logic [XLEN-1:0]   imm_ext_d;
    logic [XLEN-1:0]   pc_d;
    logic [REG_AW-1:0] rs1_d;
    logic [REG_AW-1:0] rs2_d;
    logic [REG_AW-1:0] rd_d;
    logic              reg_write_d;
    logic              mem_write_d;
    logic              alu_src_d;
    logic              branch_d;
    logic [1:0]        result_src_d;
    logic [2:0]        alu_control_d;
    logic              flush_e;
    logic [REG_AW-1:0] rd_m;
    logic              reg_write_m;
    logic [XLEN-1:0]   alu_result_m;
    logic [REG_AW-1:0] rd_w;
    logic              reg_write_w;
    logic [XLEN-1:0]   result_w;

    logic              stall_fd;
    logic              valid_e;
    logic [XLEN-1:0]   src_a_e;
    logic [XLEN-1:0]   src_b_e;
    logic [XLEN-1:0]   write_data_e;
    logic [2:0]        alu_control_e;
    logic [REG_AW-1:0] rd_e;
    logic [XLEN-1:0]   pc_e;
    logic [XLEN-1:0]   imm_ext_e;
    logic              reg_write_e;
    logic              mem_write_e;
    logic [1:0]        result_src_e;
    logic              branch_e;

    modport master (
        output valid_d, rd1_d, rd2_d, imm_ext_d, pc_d, rs1_d, rs2_d, rd_d,
               reg_write_d, mem_write_d, alu_src_d, branch_d, result_src_d, alu_control_d,
               flush_e, rd_m, reg_write_m, alu_result_m, rd_w, reg_write_w, result_w,
        input  stall_fd, valid_e, src_a_e, src_b_e, write_data_e, alu_control_e, rd_e,
               pc_e, imm_ext_e, reg_write_e, mem_write_e, result_src_e, branch_e
    );

    modport slave (
        input  valid_d, rd1_d, rd2_d, imm_ext_d, pc_d, rs1_d, rs2_d, rd_d,
               reg_write_d, mem_write_d, alu_src_d, branch_d, result_src_d, alu_control_d,
               flush_e, rd_m, reg_write_m, alu_result_m, rd_w, reg_write_w, result_w,
        output stall_fd, valid_e, src_a_e, src_b_e, write_data_e, alu_control_e, rd_e,
               pc_e, imm_ext_e, reg_write_e, mem_write_e, result_src_e, branch_e
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the RV32I core: MEM/WB operand forwarding,
// load-use stall with bubble insertion, and branch flush; feeds the ALU directly.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm_ext;
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_write;
        logic              alu_src;
        logic              branch;
        logic [1:0]        result_src;
        logic [2:0]        alu_control;
    } ex_regs_t;

    localparam logic [1:0] RES_LOAD = 2'b01;

    ex_regs_t        ex_q;
    ex_regs_t        ex_d;
    logic            lw_stall;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;

    // A load in EX whose destination is read by the instruction in decode.
    always_comb begin
        lw_stall = ex_q.valid && (ex_q.result_src == RES_LOAD) && (ex_q.rd != '0)
                && bus.valid_d && ((ex_q.rd == bus.rs1_d) || (ex_q.rd == bus.rs2_d));
    end

    always_comb begin
        // NOTE: default-assign every field first; the bubble is the all-zero word and no path can infer a latch.
        ex_d = '0;
        if (!bus.flush_e && !lw_stall) begin
            ex_d.valid       = bus.valid_d;
            ex_d.rd1         = bus.rd1_d;
            ex_d.rd2         = bus.rd2_d;
            ex_d.imm_ext     = bus.imm_ext_d;
            ex_d.pc          = bus.pc_d;
            ex_d.rs1         = bus.rs1_d;
            ex_d.rs2         = bus.rs2_d;
            ex_d.rd          = bus.rd_d;
            ex_d.reg_write   = bus.reg_write_d;
            ex_d.mem_write   = bus.mem_write_d;
            ex_d.alu_src     = bus.alu_src_d;
            ex_d.branch      = bus.branch_d;
            ex_d.result_src  = bus.result_src_d;
            ex_d.alu_control = bus.alu_control_d;
        end
    end

    // NOTE: non-blocking assignment for state; the async clear also drops stall_fd mid-stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // MEM holds the younger result, so it wins over WB; x0 is never forwarded.
    always_comb begin
        fwd_a = ex_q.rd1;
        if (bus.reg_write_m && (bus.rd_m != '0) && (bus.rd_m == ex_q.rs1)) begin
            fwd_a = bus.alu_result_m;
        end else if (bus.reg_write_w && (bus.rd_w != '0) && (bus.rd_w == ex_q.rs1)) begin
            fwd_a = bus.result_w;
        end

        fwd_b = ex_q.rd2;
        if (bus.reg_write_m && (bus.rd_m != '0) && (bus.rd_m == ex_q.rs2)) begin
            fwd_b = bus.alu_result_m;
        end else if (bus.reg_write_w && (bus.rd_w != '0) && (bus.rd_w == ex_q.rs2)) begin
            fwd_b = bus.result_w;
        end
    end

    assign bus.stall_fd      = lw_stall && !bus.flush_e;
    assign bus.valid_e       = ex_q.valid;
    assign bus.src_a_e       = fwd_a;
    assign bus.src_b_e       = ex_q.alu_src ? ex_q.imm_ext : fwd_b;
    assign bus.write_data_e  = fwd_b;
    assign bus.alu_control_e = ex_q.alu_control;
    assign bus.rd_e          = ex_q.rd;
    assign bus.pc_e          = ex_q.pc;
    assign bus.imm_ext_e     = ex_q.imm_ext;
    assign bus.reg_write_e   = ex_q.reg_write;
    assign bus.mem_write_e   = ex_q.mem_write;
    assign bus.result_src_e  = ex_q.result_src;
    assign bus.branch_e      = ex_q.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vectors, hand-written hazard
// sequences, and randomized traffic against a behavioural pipeline-slot model.
module tb_id_ex_stage;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();
    id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] imm, input logic [1:0] rsrc, input logic rw,
                         input logic mw, input logic as, input logic [2:0] actl);
        bus.valid_d = v;       bus.rs1_d = rs1;          bus.rs2_d = rs2;
        bus.rd_d = rd;         bus.rd1_d = rd1;          bus.rd2_d = rd2;
        bus.imm_ext_d = imm;   bus.result_src_d = rsrc;  bus.reg_write_d = rw;
        bus.mem_write_d = mw;  bus.alu_src_d = as;       bus.alu_control_d = actl;
        bus.pc_d = 32'h0000_0100;
        bus.branch_d = 1'b0;
    endtask

    task automatic set_fwd(input logic [4:0] rd_m, input logic rw_m, input logic [31:0] alu_m,
                           input logic [4:0] rd_w, input logic rw_w, input logic [31:0] res_w);
        bus.rd_m = rd_m; bus.reg_write_m = rw_m; bus.alu_result_m = alu_m;
        bus.rd_w = rd_w; bus.reg_write_w = rw_w; bus.result_w = res_w;
    endtask

    task automatic rand_inputs();
        bus.valid_d       = ($urandom_range(0, 5) != 0);
        bus.rd1_d         = $urandom;
        bus.rd2_d         = $urandom;
        bus.imm_ext_d     = $urandom;
        bus.pc_d          = $urandom;
        bus.rs1_d         = 5'($urandom_range(0, 4));
        bus.rs2_d         = 5'($urandom_range(0, 4));
        bus.rd_d          = 5'($urandom_range(0, 4));
        bus.reg_write_d   = 1'($urandom);
        bus.mem_write_d   = 1'($urandom);
        bus.alu_src_d     = 1'($urandom);
        bus.branch_d      = 1'($urandom);
        bus.result_src_d  = 2'($urandom_range(0, 2));
        bus.alu_control_d = 3'($urandom);
        bus.flush_e       = ($urandom_range(0, 7) == 0);
        set_fwd(5'($urandom_range(0, 4)), 1'($urandom), $urandom,
                5'($urandom_range(0, 4)), 1'($urandom), $urandom);
    endtask

    // Behavioural model: contents of the EX slot, or a bubble.
    typedef struct {
        logic        valid;
        logic        known;
        logic [31:0] rd1, rd2, imm, pc;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mw, as, br;
        logic [1:0]  rsrc;
        logic [2:0]  actl;
    } slot_t;

    slot_t m_e;

    function automatic slot_t empty_slot(input logic known);
        slot_t s;
        s.valid = 0; s.known = known; s.rd1 = 0; s.rd2 = 0; s.imm = 0; s.pc = 0;
        s.rs1 = 0; s.rs2 = 0; s.rd = 0; s.rw = 0; s.mw = 0; s.as = 0; s.br = 0;
        s.rsrc = 0; s.actl = 0;
        return s;
    endfunction

    function automatic logic [31:0] model_fwd(input logic [4:0] rs, input logic [31:0] rf);
        if (bus.reg_write_m && bus.rd_m != 0 && bus.rd_m == rs) return bus.alu_result_m;
        if (bus.reg_write_w && bus.rd_w != 0 && bus.rd_w == rs) return bus.result_w;
        return rf;
    endfunction

    function automatic logic model_load_use();
        return m_e.valid && m_e.rsrc == 2'b01 && m_e.rd != 0 && bus.valid_d
            && (m_e.rd == bus.rs1_d || m_e.rd == bus.rs2_d);
    endfunction

    task automatic model_cycle();
        slot_t nx;
        logic [31:0] b_exp;
        @(negedge clk);
        check("stall_fd", bus.stall_fd, model_load_use() && !bus.flush_e);
        check("valid_e", bus.valid_e, m_e.valid);
        check("rd_e", bus.rd_e, m_e.rd);
        check("reg_write_e", bus.reg_write_e, m_e.rw);
        check("mem_write_e", bus.mem_write_e, m_e.mw);
        check("branch_e", bus.branch_e, m_e.br);
        check("result_src_e", bus.result_src_e, m_e.rsrc);
        check("alu_control_e", bus.alu_control_e, m_e.actl);
        if (m_e.known) begin
            b_exp = m_e.as ? m_e.imm : model_fwd(m_e.rs2, m_e.rd2);
            check("pc_e", bus.pc_e, m_e.pc);
            check("imm_ext_e", bus.imm_ext_e, m_e.imm);
            check("src_a_e", bus.src_a_e, model_fwd(m_e.rs1, m_e.rd1));
            check("src_b_e", bus.src_b_e, b_exp);
            check("write_data_e", bus.write_data_e, model_fwd(m_e.rs2, m_e.rd2));
        end
        if (bus.flush_e || model_load_use()) begin
            nx = empty_slot(1'b0);
        end else begin
            nx.valid = bus.valid_d;    nx.known = 1'b1;
            nx.rd1 = bus.rd1_d;        nx.rd2 = bus.rd2_d;
            nx.imm = bus.imm_ext_d;    nx.pc = bus.pc_d;
            nx.rs1 = bus.rs1_d;        nx.rs2 = bus.rs2_d;   nx.rd = bus.rd_d;
            nx.rw = bus.reg_write_d;   nx.mw = bus.mem_write_d;
            nx.as = bus.alu_src_d;     nx.br = bus.branch_d;
            nx.rsrc = bus.result_src_d; nx.actl = bus.alu_control_d;
        end
        tick();
        m_e = nx;
    endtask

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic [31:0] rd1, rd2, imm;
        logic        as;
        logic [2:0]  actl;
        logic [4:0]  rd_m;
        logic        rw_m;
        logic [31:0] alu_m;
        logic [4:0]  rd_w;
        logic        rw_w;
        logic [31:0] res_w;
        logic [31:0] exp_a, exp_b, exp_wd;
        logic [2:0]  exp_ctl;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{5'd5, 5'd6, 32'h11, 32'h22, 32'h0, 1'b0, 3'd0, 5'd5, 1'b1, 32'h1234,
                    5'd0, 1'b0, 32'h0, 32'h1234, 32'h22, 32'h22, 3'd0};
        vecs[1] = '{5'd5, 5'd6, 32'h11, 32'h22, 32'h0, 1'b0, 3'd2, 5'd5, 1'b1, 32'h1234,
                    5'd5, 1'b1, 32'hBEEF, 32'h1234, 32'h22, 32'h22, 3'd2};
        vecs[2] = '{5'd1, 5'd7, 32'h44, 32'h33, 32'h0, 1'b0, 3'd3, 5'd0, 1'b0, 32'h0,
                    5'd7, 1'b1, 32'hA5, 32'h44, 32'hA5, 32'hA5, 3'd3};
        vecs[3] = '{5'd2, 5'd0, 32'h10, 32'h55, 32'h0, 1'b0, 3'd4, 5'd0, 1'b1, 32'h66,
                    5'd0, 1'b1, 32'h99, 32'h10, 32'h55, 32'h55, 3'd4};
        vecs[4] = '{5'd3, 5'd7, 32'h20, 32'h66, 32'hFFFF_FFFC, 1'b1, 3'd1, 5'd7, 1'b1, 32'h77,
                    5'd0, 1'b0, 32'h0, 32'h20, 32'hFFFF_FFFC, 32'h77, 3'd1};
        vecs[5] = '{5'd9, 5'd10, 32'hAA, 32'hCC, 32'h0, 1'b0, 3'd6, 5'd9, 1'b0, 32'h1,
                    5'd9, 1'b1, 32'hBB, 32'hBB, 32'hCC, 32'hCC, 3'd6};
        vecs[6] = '{5'd4, 5'd4, 32'h1, 32'h2, 32'h0, 1'b0, 3'd7, 5'd4, 1'b1, 32'h3C,
                    5'd4, 1'b1, 32'h5A, 32'h3C, 32'h3C, 32'h3C, 3'd7};

        // Reset with arbitrary inputs: every output is zero.
        rand_inputs();
        #12;
        check("rst stall_fd", bus.stall_fd, 0);
        check("rst valid_e", bus.valid_e, 0);
        check("rst src_a_e", bus.src_a_e, 0);
        check("rst src_b_e", bus.src_b_e, 0);
        check("rst write_data_e", bus.write_data_e, 0);
        check("rst alu_control_e", bus.alu_control_e, 0);
        check("rst rd_e", bus.rd_e, 0);
        check("rst pc_e", bus.pc_e, 0);
        check("rst imm_ext_e", bus.imm_ext_e, 0);
        check("rst reg_write_e", bus.reg_write_e, 0);
        check("rst mem_write_e", bus.mem_write_e, 0);
        check("rst result_src_e", bus.result_src_e, 0);
        check("rst branch_e", bus.branch_e, 0);

        // Release; the decoded instruction appears in EX one clock later.
        bus.flush_e = 1'b0;
        set_fwd(0, 0, 0, 0, 0, 0);
        set_d(1, 5'd1, 5'd2, 5'd4, 32'hDEAD_0001, 32'hDEAD_0002, 32'h10, 2'd2, 1, 1, 0, 3'd5);
        bus.pc_d = 32'h400;
        bus.branch_d = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("rel valid_e", bus.valid_e, 1);
        check("rel pc_e", bus.pc_e, 32'h400);
        check("rel imm_ext_e", bus.imm_ext_e, 32'h10);
        check("rel rd_e", bus.rd_e, 4);
        check("rel src_a_e", bus.src_a_e, 32'hDEAD_0001);
        check("rel src_b_e", bus.src_b_e, 32'hDEAD_0002);
        check("rel alu_control_e", bus.alu_control_e, 5);
        check("rel result_src_e", bus.result_src_e, 2);
        check("rel ctl_bits", {bus.reg_write_e, bus.mem_write_e, bus.branch_e}, 3'b111);

        // Forwarding / operand-select vectors.
        for (int i = 0; i < 7; i++) begin
            set_fwd(0, 0, 0, 0, 0, 0);
            set_d(1, vecs[i].rs1, vecs[i].rs2, 5'd1, vecs[i].rd1, vecs[i].rd2, vecs[i].imm,
                  2'd0, 1, 0, vecs[i].as, vecs[i].actl);
            tick();
            set_fwd(vecs[i].rd_m, vecs[i].rw_m, vecs[i].alu_m,
                    vecs[i].rd_w, vecs[i].rw_w, vecs[i].res_w);
            #1;
            check($sformatf("vec%0d src_a_e", i), bus.src_a_e, vecs[i].exp_a);
            check($sformatf("vec%0d src_b_e", i), bus.src_b_e, vecs[i].exp_b);
            check($sformatf("vec%0d write_data_e", i), bus.write_data_e, vecs[i].exp_wd);
            check($sformatf("vec%0d alu_control_e", i), bus.alu_control_e, vecs[i].exp_ctl);
        end

        // Load-use: one stall cycle, one bubble, then WB forwarding of the load.
        set_fwd(0, 0, 0, 0, 0, 0);
        set_d(1, 5'd2, 5'd0, 5'd3, 32'h0, 32'h0, 32'h8, 2'd1, 1, 0, 1, 3'd0);
        tick();
        set_d(1, 5'd3, 5'd4, 5'd5, 32'h0, 32'h44, 32'h0, 2'd0, 1, 0, 0, 3'd0);
        #1;
        check("lu stall_fd", bus.stall_fd, 1);
        tick();
        check("lu bubble valid_e", bus.valid_e, 0);
        check("lu bubble reg_write_e", bus.reg_write_e, 0);
        check("lu bubble stall_fd", bus.stall_fd, 0);
        tick();
        set_fwd(0, 0, 0, 5'd3, 1, 32'hCAFE);
        #1;
        check("lu add valid_e", bus.valid_e, 1);
        check("lu add rd_e", bus.rd_e, 5);
        check("lu add src_a_e", bus.src_a_e, 32'hCAFE);
        check("lu add stall_fd", bus.stall_fd, 0);

        // Flush beats a simultaneous load-use condition.
        set_fwd(0, 0, 0, 0, 0, 0);
        set_d(1, 5'd2, 5'd0, 5'd3, 32'h0, 32'h0, 32'h8, 2'd1, 1, 0, 1, 3'd0);
        tick();
        set_d(1, 5'd3, 5'd4, 5'd5, 32'h0, 32'h44, 32'h0, 2'd0, 1, 1, 0, 3'd0);
        bus.flush_e = 1'b1;
        #1;
        check("flush stall_fd", bus.stall_fd, 0);
        tick();
        bus.flush_e = 1'b0;
        bus.valid_d = 1'b0;
        #1;
        check("flush valid_e", bus.valid_e, 0);
        check("flush mem_write_e", bus.mem_write_e, 0);

        // Reset in the middle of a stall drops stall_fd without a clock edge.
        set_d(1, 5'd2, 5'd0, 5'd3, 32'h0, 32'h0, 32'h8, 2'd1, 1, 0, 1, 3'd0);
        tick();
        set_d(1, 5'd6, 5'd3, 5'd5, 32'h0, 32'h0, 32'h0, 2'd0, 1, 0, 0, 3'd0);
        #1;
        check("rststall stall_fd before", bus.stall_fd, 1);
        rst = 1'b0;
        #1;
        check("rststall stall_fd after", bus.stall_fd, 0);
        check("rststall valid_e", bus.valid_e, 0);
        rst = 1'b1;
        m_e = empty_slot(1'b1);

        // Randomized traffic against the slot model.
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            model_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
